// File: rtl/control_unit_if.sv
// control_unit_if: run/memory/IR inputs and datapath control strobes of the sequencer
interface control_unit_if #(parameter int NREGS = 16, parameter int OPW = 5);
  logic run, mem_ready;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic IncPC, Read;
  logic [NREGS-1:0] Rin, Rout;
  logic [OPW-1:0] alu_op;
  logic instr_done, halted;
  modport master(
    input run, mem_ready, IR,
    output PCout, Zhighout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin,
    Yin, HIin, LOin, IncPC, Read, Rin, Rout, alu_op, instr_done, halted
  );
  modport slave(
    output run, mem_ready, IR,
    input PCout, Zhighout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin,
    Yin, HIin, LOin, IncPC, Read, Rin, Rout, alu_op, instr_done, halted
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Moore fetch/decode/execute sequencer for the CPU datapath
module control_unit #(
  parameter int NREGS = 16,
  parameter int OPW = 5
) (
  input logic Clock,
  input logic clear,
  control_unit_if.master bus
);
  localparam logic [3:0] IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4;
  localparam logic [3:0] T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8;
  logic [3:0] state, state_nxt;
  logic [4:0] op;
  logic [3:0] ra, rb, rc, rout_idx;
  logic rr, imm, md, nn, hlt, nop, rout_en, rin_en;
  logic [NREGS-1:0] one;
  logic unused_ir;
  assign op = bus.IR[31:27];
  assign ra = bus.IR[26:23];
  assign rb = bus.IR[22:19];
  assign rc = bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];
  assign one = NREGS'(1);
  assign rr = op >= 5'd3 && op <= 5'd11;
  assign imm = op >= 5'd12 && op <= 5'd14;
  assign md = op == 5'd15 || op == 5'd16;
  assign nn = op == 5'd17 || op == 5'd18;
  assign hlt = op == 5'd27;
  assign nop = !(rr || imm || md || nn || hlt);
  // next step of the instruction sequence
  always_comb begin
    state_nxt = state == IDLE ? (bus.run ? T0 : IDLE) :
                state == T0 ? T1 :
                state == T1 ? (bus.mem_ready ? T2 : T1) :
                state == T2 ? T3 :
                state == T3 ? (hlt ? HALT : nop ? IDLE : T4) :
                state == T4 ? (nn ? IDLE : T5) :
                state == T5 ? (md ? T6 : IDLE) :
                state == HALT ? HALT : IDLE;
  end
  // state register; clear low forces IDLE from any state
  always_ff @(posedge Clock) begin
    state <= !clear ? IDLE : state_nxt;
  end
  assign bus.PCout = state == T0;
  assign bus.MARin = state == T0;
  assign bus.IncPC = state == T0;
  assign bus.Zin = state == T0 || (state == T3 && nn) || (state == T4 && (rr || imm || md));
  assign bus.Read = state == T1;
  assign bus.MDRin = state == T1;
  assign bus.MDRout = state == T2;
  assign bus.IRin = state == T2;
  assign bus.Yin = state == T3 && (rr || imm || md);
  assign bus.Cout = state == T4 && imm;
  assign bus.Zlowout = (state == T4 && nn) || (state == T5 && (rr || imm || md));
  assign bus.LOin = state == T5 && md;
  assign bus.Zhighout = state == T6;
  assign bus.HIin = state == T6;
  assign bus.PCin = 1'b0;
  assign bus.halted = state == HALT;
  assign bus.instr_done = (state == T3 && (nop || hlt)) || (state == T4 && nn) ||
                          (state == T5 && (rr || imm)) || state == T6;
  // one-hot register selects; drive and load never overlap in a step
  always_comb begin
    rout_en = (state == T3 && (rr || imm || md || nn)) || (state == T4 && (rr || md));
    rout_idx = state == T3 ? (md ? ra : rb) : (md ? rb : rc);
    rin_en = (state == T4 && nn) || (state == T5 && (rr || imm));
    bus.Rout = rout_en ? one << rout_idx : '0;
    bus.Rin = rin_en ? one << ra : '0;
  end
  // ALU opcode, with immediates mapped onto their register-form operation
  always_comb begin
    bus.alu_op = (state == T3 && nn) || (state == T4 && (rr || md)) ? OPW'(op) :
                 state == T4 && imm ? (op == 5'd12 ? OPW'(5'd3) : op == 5'd13 ? OPW'(5'd5) : OPW'(5'd6)) :
                 '0;
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for the control_unit sequencer
module tb_control_unit;
  typedef struct packed {
    logic PCout, Zhighout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin;
    logic Yin, HIin, LOin, IncPC, Read, instr_done, halted;
    logic [15:0] Rin, Rout;
    logic [4:0] alu_op;
  } ov_t;
  typedef struct {
    string tag;
    ov_t v;
  } sb_t;
  logic Clock, clear;
  int total = 0, bad = 0;
  sb_t q[$];
  control_unit_if #(.NREGS(16), .OPW(5)) bus();
  control_unit #(.NREGS(16), .OPW(5)) dut(.Clock(Clock), .clear(clear), .bus(bus));
  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end
  function automatic ov_t obs();
    ov_t o;
    o = {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.Cout, bus.MARin, bus.Zin,
         bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.HIin, bus.LOin, bus.IncPC, bus.Read,
         bus.instr_done, bus.halted, bus.Rin, bus.Rout, bus.alu_op};
    return o;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic put(input string tag, input ov_t v);
    sb_t s;
    s.tag = tag;
    s.v = v;
    q.push_back(s);
  endtask
  always @(negedge Clock) begin
    sb_t s;
    if (q.size() > 0) begin
      s = q.pop_front();
      chk(s.tag, obs(), s.v);
    end
  end
  task automatic instr(input string name, input logic [31:0] ir, input int waits, input int nhalt);
    ov_t e;
    logic [4:0] op;
    logic [15:0] a, b, c;
    int n;
    op = ir[31:27];
    a = 16'h1 << ir[26:23];
    b = 16'h1 << ir[22:19];
    c = 16'h1 << ir[18:15];
    @(posedge Clock);
    #1;
    bus.IR = ir;
    bus.run = 1;
    bus.mem_ready = waits == 0;
    e = '0;
    put({name, "_idle"}, e);
    e = '0; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1;
    put({name, "_t0"}, e);
    for (int i = 0; i <= waits; i++) begin
      e = '0; e.Read = 1; e.MDRin = 1;
      put({name, "_t1"}, e);
    end
    e = '0; e.MDRout = 1; e.IRin = 1;
    put({name, "_t2"}, e);
    if (op >= 5'd3 && op <= 5'd14) begin
      e = '0; e.Rout = b; e.Yin = 1;
      put({name, "_t3"}, e);
      e = '0; e.Zin = 1;
      if (op <= 5'd11) begin
        e.Rout = c;
        e.alu_op = op;
      end else begin
        e.Cout = 1;
        e.alu_op = op == 5'd12 ? 5'd3 : op == 5'd13 ? 5'd5 : 5'd6;
      end
      put({name, "_t4"}, e);
      e = '0; e.Zlowout = 1; e.Rin = a; e.instr_done = 1;
      put({name, "_t5"}, e);
    end else if (op == 5'd15 || op == 5'd16) begin
      e = '0; e.Rout = a; e.Yin = 1;
      put({name, "_t3"}, e);
      e = '0; e.Rout = b; e.Zin = 1; e.alu_op = op;
      put({name, "_t4"}, e);
      e = '0; e.Zlowout = 1; e.LOin = 1;
      put({name, "_t5"}, e);
      e = '0; e.Zhighout = 1; e.HIin = 1; e.instr_done = 1;
      put({name, "_t6"}, e);
    end else if (op == 5'd17 || op == 5'd18) begin
      e = '0; e.Rout = b; e.Zin = 1; e.alu_op = op;
      put({name, "_t3"}, e);
      e = '0; e.Zlowout = 1; e.Rin = a; e.instr_done = 1;
      put({name, "_t4"}, e);
    end else begin
      e = '0; e.instr_done = 1;
      put({name, "_t3"}, e);
      if (op == 5'd27)
        for (int i = 0; i < nhalt; i++) begin
          e = '0; e.halted = 1;
          put({name, "_halt"}, e);
        end
    end
    if (op != 5'd27) begin
      e = '0;
      put({name, "_end"}, e);
    end
    @(posedge Clock);
    #1;
    if (nhalt == 0) bus.run = 0;
    @(posedge Clock);
    #1;
    repeat (waits) begin
      @(posedge Clock);
      #1;
    end
    bus.mem_ready = 1;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    if (q.size() > 0) begin
      chk({name, "_timeout"}, q.size(), 0);
      q.delete();
    end
    bus.run = 0;
  endtask
  initial begin
    logic [31:0] ir;
    clear = 0;
    bus.run = 0;
    bus.mem_ready = 0;
    bus.IR = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_out", obs(), 0);
    chk("rst_halted", bus.halted, 0);
    clear = 1;
    instr("and", 32'h28918000, 0, 0);
    instr("and_wait", 32'h28918000, 3, 0);
    instr("mul", 32'h79180000, 0, 0);
    instr("addi", 32'h60900005, 0, 0);
    instr("andi", 32'h6A980007, 1, 0);
    instr("ori", 32'h7620000F, 0, 0);
    instr("div", 32'h82D00000, 2, 0);
    instr("neg", 32'h8BF80000, 0, 0);
    instr("not", 32'h90800000, 0, 0);
    instr("sub", 32'h20C68000, 0, 0);
    instr("nop", 32'hD0000000, 0, 0);
    instr("unk", 32'hF8000000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ir = {5'($urandom_range(3, 11)), 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
      instr("rnd", ir, i, 0);
    end
    instr("halt", 32'hD8000000, 0, 10);
    clear = 0;
    @(posedge Clock);
    #1;
    chk("halt_clr1", obs(), 0);
    @(posedge Clock);
    #1;
    chk("halt_clr2", obs(), 0);
    clear = 1;
    @(posedge Clock);
    #1;
    chk("halt_idle", obs(), 0);
    bus.IR = 32'h28918000;
    bus.run = 1;
    bus.mem_ready = 1;
    @(posedge Clock);
    #1;
    bus.run = 0;
    repeat (4) @(posedge Clock);
    #1;
    chk("t4_zin", bus.Zin, 1);
    chk("t4_rout", bus.Rout, 16'h0008);
    clear = 0;
    @(posedge Clock);
    #1;
    chk("t4_rst", obs(), 0);
    clear = 1;
    @(posedge Clock);
    #1;
    chk("t4_idle", obs(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore sequencer that drives the CPU datapath through fetch, decode and execute.
- Issues the one-hot register enables, bus-source strobes, latch strobes and the ALU opcode, one control step per clock.
- Supports register-register ALU ops, immediates, mul/div, neg/not, nop and halt, with a memory-ready wait on fetch.
- Sits beside the datapath and replaces the hand-sequenced control stimulus.

Parameters:
- NREGS, 16, number of general registers (width of Rin/Rout).
- OPW, 5, opcode/alu_op width.

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-low reset; clear=0 resets at the next rising edge.
- run  in  1  permits starting a new instruction.
- mem_ready  in  1  memory data valid on Mdatain this cycle.
- IR  in  32  instruction register contents from datapath.
- PCout, Zhighout, Zlowout, MDRout, Cout  out  1 each  bus-source strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  out  1 each  latch strobes.
- IncPC, Read  out  1 each  PC increment, memory read.
- Rin  out  NREGS  one-hot register load enables.
- Rout  out  NREGS  one-hot register drive enables.
- alu_op  out  OPW  ALU operation code.
- instr_done  out  1  one-cycle pulse in the final step of each instruction.
- halted  out  1  high while in HALT.

Behaviour:
- IR fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Opcodes: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011. Any other op is treated as nop.
- Outputs are a pure decode of the state register and IR; the datapath latches them at the following rising edge.
- Every strobe is 0 in IDLE and HALT. In every state, every strobe not listed for that state is 0, alu_op=0 and Rin/Rout are all zero.
- Reset: at a rising edge with clear=0, state becomes IDLE regardless of current state, with all outputs 0 and halted=0. Strobes of the interrupted state remain asserted until that edge.
- States and transitions:
  - IDLE: go to T0 if run=1, else stay.
  - T0: PCout, MARin, IncPC, Zin; go to T1.
  - T1: Read, MDRin. Stay while mem_ready=0; go to T2 when mem_ready=1.
  - T2: MDRout, IRin; go to T3.
  - T3 for reg-reg and immediate ops: Rout[Rb], Yin.
  - T3 for mul/div: Rout[Ra], Yin.
  - T3 for neg/not: Rout[Rb], Zin, alu_op=op.
  - T3 for nop: instr_done, then go to IDLE.
  - T3 for halt: instr_done, then go to HALT.
  - T4 for reg-reg: Rout[Rc], Zin, alu_op=op.
  - T4 for immediates: Cout, Zin, alu_op = 00011 / 00101 / 00110 for addi / andi / ori.
  - T4 for mul/div: Rout[Rb], Zin, alu_op=op.
  - T4 for neg/not: Zlowout, Rin[Ra], instr_done; go to IDLE.
  - T5 for reg-reg and immediates: Zlowout, Rin[Ra], instr_done; go to IDLE.
  - T5 for mul/div: Zlowout, LOin.
  - T6 (mul/div only): Zhighout, HIin, instr_done; go to IDLE.
  - HALT: halted=1; leaves only via clear=0. run is ignored.
- Latency from T0 with mem_ready high in T1:
  - reg-reg and immediate: 6 cycles.
  - mul/div: 7 cycles.
  - neg/not: 5 cycles.
  - nop: 4 cycles.
  - Each cycle of mem_ready=0 adds 1. An IDLE cycle separates consecutive instructions.
- Rin and Rout are never both nonzero in the same cycle, and each is at most one-hot.
- IR changes outside T2 do not affect the state already decoded; decode uses IR from T3 onward.
- PCin is reserved and stays 0.

Test Plan:
- Reset: hold clear=0 for 2 cycles from any state -> state IDLE, all outputs 0, halted=0. Repeat with reset asserted during T4 -> next cycle IDLE.
- IR=0x28918000 (and R1,R2,R3), run=1, mem_ready=1:
  - T3: Rout=0x0004, Yin=1.
  - T4: Rout=0x0008, alu_op=00101, Zin=1.
  - T5: Rin=0x0002, Zlowout=1, instr_done=1.
  - Then IDLE.
- Fetch wait: mem_ready held 0 for 3 cycles -> Read and MDRin stay 1 for 4 cycles; IRin asserts exactly once, in the cycle after mem_ready=1.
- mul R2,R3 (IR=0x79180000):
  - T3: Rout=0x0004, Yin=1.
  - T4: Rout=0x0008, alu_op=01111, Zin=1.
  - T5: Zlowout=1, LOin=1.
  - T6: Zhighout=1, HIin=1, instr_done=1.
- addi R1,R2 (IR=0x60900005): T4 asserts Cout=1, alu_op=00011, Zin=1, Rout=0.
- halt (IR=0xD8000000) -> halted=1 after T3, stays through 10 cycles with run=1. clear=0 returns it to IDLE. Unknown op 11111 behaves as nop: instr_done in T3, then IDLE.
